// File: rtl/bin_bcd_seq_if.sv
// bin_bcd_seq_if: source, divider and display signals of the binary-to-BCD sequencer.
interface bin_bcd_seq_if;
    logic        start;
    logic [7:0]  bindata;
    logic        div_ce;
    logic        div_rfd;
    logic [7:0]  dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  fractional;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        busy;
    logic        done;
    modport master (
        output start, bindata, div_rfd, quotient, fractional,
        input  div_ce, dividend, divisor, bcd, blank, busy, done
    );
    modport slave (
        input  start, bindata, div_rfd, quotient, fractional,
        output div_ce, dividend, divisor, bcd, blank, busy, done
    );
endinterface

// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: converts an 8-bit value to three BCD digits via three sequenced divide-by-10 operations.
module bin_bcd_seq #(
    parameter int DIV_LATENCY = 4
) (
    input logic          CLK,
    input logic          RESET,
    bin_bcd_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;
    localparam logic [5:0] WLAST = 6'(DIV_LATENCY - 1);
    state_t      state_q, state_d;
    logic [7:0]  work_q, work_d;
    logic [1:0]  idx_q, idx_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic [11:0] shadow_q, shadow_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  blank_q, blank_d;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            work_q   <= '0;
            idx_q    <= '0;
            wcnt_q   <= '0;
            shadow_q <= '0;
            bcd_q    <= '0;
            blank_q  <= 3'b110;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            shadow_q <= shadow_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        shadow_d = shadow_q;
        bcd_d    = bcd_q;
        blank_d  = blank_q;
        case (state_q)
            IDLE: if (bus.start) begin
                work_d  = bus.bindata;
                idx_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: if (bus.div_rfd) begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wcnt_d  = wcnt_q + 6'd1;
                state_d = (wcnt_q == WLAST) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                shadow_d[{idx_q, 2'b00} +: 4] = bus.fractional[3:0];
                work_d  = bus.quotient;
                idx_d   = (idx_q == 2'd2) ? idx_q : idx_q + 2'd1;
                state_d = (idx_q == 2'd2) ? DONE : ISSUE;
            end
            DONE: begin
                bcd_d   = shadow_q;
                // ones digit is never blanked so a value of 0 still shows "0"
                blank_d = {shadow_q[11:8] == 4'd0, shadow_q[11:4] == 8'd0, 1'b0};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.div_ce   = (state_q == ISSUE) && bus.div_rfd;
    assign bus.dividend = work_q;
    assign bus.divisor  = 8'd10;
    assign bus.bcd      = bcd_q;
    assign bus.blank    = blank_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb_bin_bcd_seq: table-driven, hand-sequenced and random checks of bin_bcd_seq against a behavioural divider and BCD model.
module tb_bin_bcd_seq;
    localparam int L = 4;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    bin_bcd_seq_if bus ();
    bin_bcd_seq #(.DIV_LATENCY(L)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    int tests = 0;
    int fails = 0;
    logic [7:0] ceq[$];
    logic [7:0] pq, pf;
    int pend = 0;
    // divider: result appears L cycles after the ce cycle and is held until the next ce
    always @(posedge CLK) begin
        if (bus.div_ce) begin
            pq <= bus.dividend / 8'd10;
            pf <= bus.dividend % 8'd10;
            pend <= L;
            bus.quotient <= 8'hEE;
            bus.fractional <= 8'hEE;
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                bus.quotient <= pq;
                bus.fractional <= pf;
            end
        end
    end
    typedef struct {
        logic [7:0]  v;
        int          sf;
        int          sn;
        logic [7:0]  poke;
        logic [11:0] bcd;
        logic [2:0]  blank;
        int          dcyc;
    } vec_t;
    vec_t tbl[10];
    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    function automatic logic [2:0] ref_blank(input int v);
        return {v < 100, v < 10, 1'b0};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // starts at a negedge, ends at the negedge of the first IDLE cycle after done
    task automatic run(input logic [7:0] v, input int sf, input int sn, input logic [7:0] poke, output int dcyc);
        logic [11:0] bcd0;
        bit stable, busyok;
        bcd0 = bus.bcd;
        stable = 1;
        busyok = 1;
        ceq.delete();
        bus.start = 1'b1;
        bus.bindata = v;
        dcyc = -1;
        for (int c = 1; c <= 300 && dcyc < 0; c++) begin
            @(posedge CLK); #1;
            bus.start = (poke != 8'd0) && (c == 3 || c == L + 2);
            bus.bindata = bus.start ? poke : v;
            bus.div_rfd = !(c >= sf && c < sf + sn);
            @(negedge CLK);
            if (bus.div_ce) ceq.push_back(bus.dividend);
            if (!bus.busy) busyok = 0;
            if (bus.bcd !== bcd0) stable = 0;
            if (bus.done) dcyc = c;
        end
        @(posedge CLK); #1;
        bus.start = 1'b0;
        bus.div_rfd = 1'b1;
        @(negedge CLK);
        check("busy_during", 32'(busyok), 1);
        check("bcd_stable", 32'(stable), 1);
        check("busy_after", 32'(bus.busy), 0);
        check("done_width", 32'(bus.done), 0);
    endtask
    task automatic conv(input logic [7:0] v, input int sf, input int sn, input logic [7:0] poke,
                        input logic [11:0] eb, input logic [2:0] ebl, input int ed);
        int d;
        int m;
        run(v, sf, sn, poke, d);
        check($sformatf("done_cycle(%0d)", v), 32'(d), 32'(ed));
        check($sformatf("bcd(%0d)", v), 32'(bus.bcd), 32'(eb));
        check($sformatf("blank(%0d)", v), 32'(bus.blank), 32'(ebl));
        check($sformatf("ndiv(%0d)", v), 32'(ceq.size()), 3);
        m = v;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dividend%0d(%0d)", i, v), (i < ceq.size()) ? 32'(ceq[i]) : 32'hFFFF_FFFF, 32'(m));
            m = m / 10;
        end
    endtask
    initial begin
        int rv, rn;
        bit seen;
        tbl[0] = '{8'd255, 0, 0, 8'd0,  12'h255, 3'b000, 19};
        tbl[1] = '{8'd0,   0, 0, 8'd0,  12'h000, 3'b110, 19};
        tbl[2] = '{8'd7,   0, 0, 8'd0,  12'h007, 3'b110, 19};
        tbl[3] = '{8'd42,  0, 0, 8'd0,  12'h042, 3'b100, 19};
        tbl[4] = '{8'd100, 7, 5, 8'd0,  12'h100, 3'b000, 24};
        tbl[5] = '{8'd128, 0, 0, 8'd77, 12'h128, 3'b000, 19};
        tbl[6] = '{8'd9,   0, 0, 8'd0,  12'h009, 3'b110, 19};
        tbl[7] = '{8'd10,  0, 0, 8'd0,  12'h010, 3'b100, 19};
        tbl[8] = '{8'd99,  0, 0, 8'd0,  12'h099, 3'b100, 19};
        tbl[9] = '{8'd200, 1, 2, 8'd0,  12'h200, 3'b000, 21};
        bus.start = 1'b1;
        bus.bindata = 8'd55;
        bus.div_rfd = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_ce", 32'(bus.div_ce), 0);
        check("rst_bcd", 32'(bus.bcd), 0);
        check("rst_blank", 32'(bus.blank), 32'b110);
        check("divisor", 32'(bus.divisor), 10);
        @(posedge CLK); #1;
        RESET = 1'b0;
        bus.start = 1'b0;
        @(negedge CLK);
        check("start_with_reset_dropped", 32'(bus.busy), 0);
        foreach (tbl[i]) conv(tbl[i].v, tbl[i].sf, tbl[i].sn, tbl[i].poke, tbl[i].bcd, tbl[i].blank, tbl[i].dcyc);
        bus.start = 1'b1;
        bus.bindata = 8'd199;
        repeat (9) begin
            @(posedge CLK); #1;
            bus.start = 1'b0;
        end
        @(negedge CLK);
        check("mid_busy", 32'(bus.busy), 1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_bcd", 32'(bus.bcd), 0);
        check("abort_blank", 32'(bus.blank), 32'b110);
        check("abort_ce", 32'(bus.div_ce), 0);
        seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (bus.done || bus.busy) seen = 1;
        end
        check("abort_no_done", 32'(seen), 0);
        conv(8'd199, 0, 0, 8'd0, 12'h199, 3'b000, 19);
        for (int i = 0; i < 20; i++) begin
            rv = $urandom_range(255);
            rn = $urandom_range(3);
            conv(8'(rv), 1, rn, 8'd0, ref_bcd(rv), ref_blank(rv), 3 * (L + 2) + 1 + rn);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
